// File: rtl/io_uart_pkg.sv
// Shared constants, state encodings and helpers for the io_uart peripheral.
package io_uart_pkg;

  localparam logic [1:0]  UartDataAddr = 2'd0;
  localparam logic [1:0]  UartStatAddr = 2'd1;
  localparam logic [1:0]  UartDivAddr  = 2'd2;
  localparam logic [1:0]  UartCtrlAddr = 2'd3;

  localparam logic [31:0] ZeroWord     = 32'h0000_0000;
  localparam logic        ChipEnable   = 1'b1;
  localparam logic        WriteEnable  = 1'b1;

  typedef enum logic [1:0] {TX_IDLE = 2'd0, TX_START = 2'd1, TX_DATA = 2'd2, TX_STOP = 2'd3} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE = 2'd0, RX_START = 2'd1, RX_DATA = 2'd2, RX_STOP = 2'd3} rx_state_t;

  // A programmed divisor of zero behaves as one clock per bit.
  function automatic logic [15:0] eff_div(input logic [15:0] d);
    return (d == 16'd0) ? 16'd1 : d;
  endfunction

endpackage

// File: rtl/io_uart_if.sv
// IO-side bus between the memory/IO controller (master) and the UART (slave).
interface io_uart_if;
  // Single-cycle strobe bus, no handshake: a write commits on the rising clock
  // edge when io_ce_i & iowenb_i; a read is io_ce_i & !iowenb_i and rdata_o is
  // valid combinationally in the same cycle (zero when not reading).
  logic        io_ce_i;
  logic        iowenb_i;
  logic [31:0] ioaddr_i;
  logic [31:0] wiodata_i;
  logic [31:0] rdata_o;

  modport master (output io_ce_i, output iowenb_i, output ioaddr_i, output wiodata_i, input rdata_o);
  modport slave  (input io_ce_i, input iowenb_i, input ioaddr_i, input wiodata_i, output rdata_o);
endinterface

// File: rtl/io_uart_fifo.sv
// Synchronous FIFO; a push while full is dropped, a pop while empty is ignored.
module io_uart_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [W-1:0]  i_din,
  output logic [W-1:0]  o_dout,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_count
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push, w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_dout    = r_mem[r_rd_ptr];
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/io_uart.sv
// Memory-mapped 8N1 UART: TX FIFO + serialiser, synchronised RX deserialiser,
// DATA/STATUS/DIVISOR/CTRL registers and a level interrupt.
module io_uart
  import io_uart_pkg::*;
#(
  parameter int          TX_DEPTH    = 8,
  parameter logic [15:0] DIV_DEFAULT = 16'd434
) (
  input  logic       clk,
  input  logic       rst,
  io_uart_if.slave   bus,
  output logic       txd_o,
  input  logic       rxd_i,
  output logic       irq_o,
  output logic [1:0] dbg_tx_state_o,
  output logic [1:0] dbg_rx_state_o
);

  logic [1:0]  w_addr;
  logic        w_rd, w_wr, w_push, w_rd_data, w_stat_wr;
  logic [15:0] r_div;
  logic        r_rx_ie, r_tx_ie;

  assign w_addr    = bus.ioaddr_i[3:2];
  assign w_rd      = (bus.io_ce_i == ChipEnable) && (bus.iowenb_i != WriteEnable);
  assign w_wr      = (bus.io_ce_i == ChipEnable) && (bus.iowenb_i == WriteEnable);
  assign w_push    = w_wr && (w_addr == UartDataAddr);
  assign w_rd_data = w_rd && (w_addr == UartDataAddr);
  assign w_stat_wr = w_wr && (w_addr == UartStatAddr);

  // ---------------- TX path ----------------
  logic [7:0]              w_fifo_dout;
  logic                    w_tx_full, w_tx_empty, w_tx_pop, w_tx_busy, w_tx_bit_end;
  logic [$clog2(TX_DEPTH):0] w_fifo_count;
  tx_state_t               r_tx_state, w_tx_next;
  logic [15:0]             r_tx_cnt, r_tx_div;
  logic [2:0]              r_tx_bit;
  logic [7:0]              r_tx_shift;

  io_uart_fifo #(.DEPTH(TX_DEPTH), .W(8)) u_fifo (
    .clk(clk), .rst_n(rst), .i_push(w_push), .i_pop(w_tx_pop),
    .i_din(bus.wiodata_i[7:0]), .o_dout(w_fifo_dout),
    .o_full(w_tx_full), .o_empty(w_tx_empty), .o_count(w_fifo_count)
  );

  assign w_tx_busy    = (r_tx_state != TX_IDLE);
  assign w_tx_bit_end = (r_tx_cnt == r_tx_div - 16'd1);

  always_comb begin
    w_tx_next = r_tx_state;
    w_tx_pop  = 1'b0;
    case (r_tx_state)
      TX_IDLE:  if (!w_tx_empty) begin w_tx_pop = 1'b1; w_tx_next = TX_START; end
      TX_START: if (w_tx_bit_end) w_tx_next = TX_DATA;
      TX_DATA:  if (w_tx_bit_end && r_tx_bit == 3'd7) w_tx_next = TX_STOP;
      TX_STOP:  if (w_tx_bit_end) begin
                  // Chain straight into the next start bit so frames run back to back.
                  if (!w_tx_empty) begin w_tx_pop = 1'b1; w_tx_next = TX_START; end
                  else w_tx_next = TX_IDLE;
                end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_div   <= eff_div(DIV_DEFAULT);
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
    end else begin
      r_tx_state <= w_tx_next;
      if (r_tx_state == TX_IDLE || w_tx_bit_end) r_tx_cnt <= '0;
      else r_tx_cnt <= r_tx_cnt + 16'd1;
      // Divisor changes take effect only at a bit boundary.
      if (w_tx_pop || (r_tx_state != TX_IDLE && w_tx_bit_end)) r_tx_div <= eff_div(r_div);
      if (w_tx_pop) begin
        r_tx_shift <= w_fifo_dout;
        r_tx_bit   <= '0;
      end else if (r_tx_state == TX_DATA && w_tx_bit_end) begin
        r_tx_shift <= {1'b0, r_tx_shift[7:1]};
        r_tx_bit   <= r_tx_bit + 3'd1;
      end
    end
  end

  always_comb begin
    txd_o = 1'b1;
    case (r_tx_state)
      TX_START: txd_o = 1'b0;
      TX_DATA:  txd_o = r_tx_shift[0];
      default:  txd_o = 1'b1;
    endcase
  end

  // ---------------- RX path ----------------
  logic        r_rx_s1, r_rx_s2, r_rx_s3;
  rx_state_t   r_rx_state, w_rx_next;
  logic [15:0] r_rx_cnt, r_rx_div, w_rx_half;
  logic [2:0]  r_rx_bit;
  logic [7:0]  r_rx_shift, r_rx_buf;
  logic        r_rx_valid, r_rx_overrun;
  logic        w_rx_fall, w_rx_full_end, w_rx_sample, w_rx_done;

  assign w_rx_fall     = r_rx_s3 & ~r_rx_s2;
  assign w_rx_half     = eff_div({1'b0, r_rx_div[15:1]});
  assign w_rx_full_end = (r_rx_cnt == r_rx_div - 16'd1);

  always_comb begin
    w_rx_next   = r_rx_state;
    w_rx_sample = 1'b0;
    w_rx_done   = 1'b0;
    case (r_rx_state)
      RX_IDLE:  if (w_rx_fall) w_rx_next = RX_START;
      RX_START: if (r_rx_cnt == w_rx_half - 16'd1) w_rx_next = r_rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_rx_full_end) begin
                  w_rx_sample = 1'b1;
                  if (r_rx_bit == 3'd7) w_rx_next = RX_STOP;
                end
      RX_STOP:  if (w_rx_full_end) begin
                  w_rx_done = r_rx_s2;
                  w_rx_next = RX_IDLE;
                end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_s1      <= 1'b1;
      r_rx_s2      <= 1'b1;
      r_rx_s3      <= 1'b1;
      r_rx_state   <= RX_IDLE;
      r_rx_cnt     <= '0;
      r_rx_div     <= eff_div(DIV_DEFAULT);
      r_rx_bit     <= '0;
      r_rx_shift   <= '0;
      r_rx_buf     <= '0;
      r_rx_valid   <= 1'b0;
      r_rx_overrun <= 1'b0;
    end else begin
      r_rx_s1    <= rxd_i;
      r_rx_s2    <= r_rx_s1;
      r_rx_s3    <= r_rx_s2;
      r_rx_state <= w_rx_next;
      if (r_rx_state == RX_IDLE || w_rx_next != r_rx_state || w_rx_full_end) r_rx_cnt <= '0;
      else r_rx_cnt <= r_rx_cnt + 16'd1;
      if (r_rx_state == RX_IDLE) begin
        r_rx_div <= eff_div(r_div);
        r_rx_bit <= '0;
      end else if (w_rx_sample) begin
        r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
        r_rx_bit   <= r_rx_bit + 3'd1;
      end
      // A DATA read on the same edge as a new byte frees the slot: no overrun.
      if (w_rx_done && !(r_rx_valid && !w_rd_data)) begin
        r_rx_buf   <= r_rx_shift;
        r_rx_valid <= 1'b1;
      end else if (w_rd_data) begin
        r_rx_valid <= 1'b0;
      end
      if (w_rx_done && r_rx_valid && !w_rd_data) r_rx_overrun <= 1'b1;
      else if (w_stat_wr) r_rx_overrun <= 1'b0;
    end
  end

  // ---------------- Registers and read mux ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div   <= DIV_DEFAULT;
      r_rx_ie <= 1'b0;
      r_tx_ie <= 1'b0;
    end else if (w_wr) begin
      if (w_addr == UartDivAddr) r_div <= bus.wiodata_i[15:0];
      if (w_addr == UartCtrlAddr) begin
        r_rx_ie <= bus.wiodata_i[0];
        r_tx_ie <= bus.wiodata_i[1];
      end
    end
  end

  always_comb begin
    bus.rdata_o = ZeroWord;
    if (w_rd) begin
      case (w_addr)
        UartDataAddr: bus.rdata_o = {24'h0, r_rx_buf};
        UartStatAddr: bus.rdata_o = {27'h0, r_rx_overrun, w_tx_busy, w_tx_empty, w_tx_full, r_rx_valid};
        UartDivAddr:  bus.rdata_o = {16'h0, r_div};
        UartCtrlAddr: bus.rdata_o = {30'h0, r_tx_ie, r_rx_ie};
      endcase
    end
  end

  assign irq_o          = (r_rx_ie & r_rx_valid) | (r_tx_ie & w_tx_empty & ~w_tx_busy);
  assign dbg_tx_state_o = r_tx_state;
  assign dbg_rx_state_o = r_rx_state;

  logic w_unused;
  assign w_unused = ^{bus.ioaddr_i[31:4], bus.ioaddr_i[1:0], bus.wiodata_i[31:16], w_fifo_count};

endmodule
